// File: rtl/ahb_sram_pkg.sv
// Shared encodings and helpers for the AHB-Lite SRAM controller.
package ahb_sram_pkg;

    // HTRANS encodings
    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;

    // HSIZE encodings (only these three are legal)
    localparam logic [2:0] SizeByte = 3'd0;
    localparam logic [2:0] SizeHalf = 3'd1;
    localparam logic [2:0] SizeWord = 3'd2;

    // Data-phase state of the slave
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWr   = 3'd1,
        StRd   = 3'd2,
        StRdw  = 3'd3,
        StErr1 = 3'd4,
        StErr2 = 3'd5
    } state_t;

    // Little-endian byte-lane mask for a (legal) transfer size and byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SizeByte: mask = 4'b0001 << off;
            SizeHalf: mask = off[1] ? 4'b1100 : 4'b0011;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_wmerge.sv
// Read-modify-write merge: replaces the masked byte lanes of the current RAM word
// with the corresponding lanes of the bus write data.
module ahb_sram_wmerge (
    input  logic [31:0] ram_q_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mask_i,
    output logic [31:0] ram_d_o
);

    // Per-lane select between old RAM contents and new bus data
    always_comb begin
        ram_d_o = ram_q_i;
        for (int b = 0; b < 4; b++) begin
            if (mask_i[b]) begin
                ram_d_o[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave front end for a single-port 32-bit word RAM with combinational read.
// Sub-word writes are single-cycle read-modify-write; misaligned or oversize transfers
// get a two-cycle ERROR response.
// Optional macro AHB_SRAM_RDREG_EN: registers read data, adding one wait state per read.
module ahb_sram_ctrl #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);
    import ahb_sram_pkg::*;

`ifdef AHB_SRAM_RDREG_EN
    localparam state_t RdEntry = StRdw;
`else
    localparam state_t RdEntry = StRd;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic              accept;
    logic              size_err;
    logic [3:0]        mask;

    // HBURST is ignored and upper address bits lie outside the RAM
    logic unused_ok;
    assign unused_ok = ^{HBURST, HADDR[31:ADDR_W+2], HTRANS[0]};

    // Address-phase accept and alignment/size check
    always_comb begin
        accept   = HSEL & HREADY & HTRANS[1];
        size_err = (HSIZE > SizeWord)
                 | ((HSIZE == SizeWord) & (HADDR[1:0] != 2'b00))
                 | ((HSIZE == SizeHalf) & HADDR[0]);
    end

    // Next state and address-phase capture
    always_comb begin
        state_d = StIdle;
        addr_d  = addr_q;
        off_d   = off_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            StErr1: state_d = StErr2;
            StRdw:  state_d = StRd;
            default: begin
                if (accept) begin
                    if (size_err) begin
                        state_d = StErr1;
                    end else if (HWRITE) begin
                        state_d = StWr;
                    end else begin
                        state_d = RdEntry;
                    end
                end
            end
        endcase
        if (accept) begin
            addr_d  = HADDR[ADDR_W+1:2];
            off_d   = HADDR[1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
        end
    end

    // State and address-phase registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Bus response and RAM control; write is suppressed while reset is asserted
    always_comb begin
        HREADYOUT = !((state_q == StErr1) || (state_q == StRdw));
        HRESP     = (state_q == StErr1) || (state_q == StErr2);
        ram_a     = addr_q;
        ram_we    = HRESETn & write_q & (state_q == StWr);
        mask      = lane_mask(size_q, off_q);
    end

    ahb_sram_wmerge u_wmerge (
        .ram_q_i (ram_q),
        .wdata_i (HWDATA),
        .mask_i  (mask),
        .ram_d_o (ram_d)
    );

`ifdef AHB_SRAM_RDREG_EN
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Capture RAM output during the read wait state
    always_comb begin
        rdata_d = (state_q == StRdw) ? ram_q : rdata_q;
        HRDATA  = rdata_q;
    end

    // Registered read data
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end
`else
    // Combinational read data straight from the RAM
    always_comb begin
        HRDATA = ram_q;
    end
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Self-checking bench for ahb_sram_ctrl: directed cases plus randomized pipelined
// traffic checked against a byte-level reference memory.
module tb_ahb_sram_ctrl;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [17:0] ram_a;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;

    bit [31:0] mem     [0:(1<<18)-1];
    bit [31:0] ref_mem [0:(1<<18)-1];

    int n_checks;
    int n_errors;

    // Transfer currently in its data phase
    bit          p_vld;
    logic [31:0] p_addr;
    bit          p_wr;
    logic [2:0]  p_size;
    logic [31:0] p_wdata;

    assign hready = hreadyout;

    ahb_sram_ctrl dut (
        .HCLK      (hclk),
        .HRESETn   (hresetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HBURST    (hburst),
        .HWDATA    (hwdata),
        .HREADY    (hready),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .HRDATA    (hrdata),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // RAM: combinational read, write on clock edge
    assign ram_q = mem[ram_a];
    always @(posedge hclk) begin
        if (ram_we) mem[ram_a] <= ram_d;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [2:0] size, input logic [31:0] addr);
        return (size > 3'd2) || (size == 3'd2 && addr[1:0] != 2'b00) ||
               (size == 3'd1 && addr[0]);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            bit take;
            take = (size == 3'd2) || (size == 3'd1 && (b / 2) == int'(addr[1])) ||
                   (size == 3'd0 && b == int'(addr[1:0]));
            if (take) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // One bus step: present a new address phase, check the pending data phase to
    // completion, then the new transfer becomes pending. Called just after a posedge.
    task automatic beat(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                        input bit wr, input logic [2:0] size, input logic [31:0] wdata);
        logic [17:0] wa;
        hsel   = sel;
        htrans = trans;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hburst = 3'($urandom_range(0, 7));
        hwdata = p_wdata;
        wa     = p_addr[19:2];
        if (!p_vld) begin
            @(negedge hclk);
            check_eq("idle_ready", 32'(hreadyout), 32'd1);
            check_eq("idle_resp", 32'(hresp), 32'd0);
            check_eq("idle_we", 32'(ram_we), 32'd0);
        end else if (is_illegal(p_size, p_addr)) begin
            @(negedge hclk);
            check_eq("err1_ready", 32'(hreadyout), 32'd0);
            check_eq("err1_resp", 32'(hresp), 32'd1);
            check_eq("err1_we", 32'(ram_we), 32'd0);
            @(posedge hclk); #1;
            @(negedge hclk);
            check_eq("err2_ready", 32'(hreadyout), 32'd1);
            check_eq("err2_resp", 32'(hresp), 32'd1);
            check_eq("err2_we", 32'(ram_we), 32'd0);
        end else if (p_wr) begin
            @(negedge hclk);
            check_eq("wr_ready", 32'(hreadyout), 32'd1);
            check_eq("wr_resp", 32'(hresp), 32'd0);
            check_eq("wr_we", 32'(ram_we), 32'd1);
            check_eq("wr_addr", 32'(ram_a), 32'(wa));
            check_eq("wr_data", ram_d, ref_merge(ref_mem[wa], p_wdata, p_size, p_addr));
        end else begin
`ifdef AHB_SRAM_RDREG_EN
            @(negedge hclk);
            check_eq("rdw_ready", 32'(hreadyout), 32'd0);
            check_eq("rdw_resp", 32'(hresp), 32'd0);
            @(posedge hclk); #1;
`endif
            @(negedge hclk);
            check_eq("rd_ready", 32'(hreadyout), 32'd1);
            check_eq("rd_resp", 32'(hresp), 32'd0);
            check_eq("rd_we", 32'(ram_we), 32'd0);
            check_eq("rd_data", hrdata, ref_mem[wa]);
        end
        @(posedge hclk); #1;
        if (p_vld && p_wr && !is_illegal(p_size, p_addr)) begin
            ref_mem[wa] = ref_merge(ref_mem[wa], p_wdata, p_size, p_addr);
        end
        p_vld   = sel && trans[1];
        p_addr  = addr;
        p_wr    = wr;
        p_size  = size;
        p_wdata = wdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
        beat(1'b1, 2'd2, addr, 1'b1, size, d);
    endtask

    task automatic rd(input logic [31:0] addr);
        beat(1'b1, 2'd2, addr, 1'b0, 3'd2, 32'h0);
    endtask

    task automatic idle();
        beat(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        p_vld    = 1'b0;
        p_addr   = '0;
        p_wr     = 1'b0;
        p_size   = '0;
        p_wdata  = '0;
        hresetn  = 1'b0;
        hsel     = 1'b0;
        htrans   = 2'd0;
        haddr    = '0;
        hwrite   = 1'b0;
        hsize    = '0;
        hburst   = '0;
        hwdata   = '0;
        repeat (3) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(negedge hclk);
        check_eq("rst_ready", 32'(hreadyout), 32'd1);
        check_eq("rst_resp", 32'(hresp), 32'd0);
        check_eq("rst_we", 32'(ram_we), 32'd0);
        check_eq("rst_addr", 32'(ram_a), 32'd0);
        @(posedge hclk); #1;

        // Word write then read
        wr(32'h100, 3'd2, 32'hDEADBEEF);
        rd(32'h100);
        idle();
        check_eq("word_rd_value", hrdata, 32'hDEADBEEF);

        // Byte write on lane 2
        wr(32'h200, 3'd2, 32'h11223344);
        wr(32'h202, 3'd0, 32'h00AA0000);
        rd(32'h200);
        // Half write on upper lanes
        wr(32'h204, 3'd2, 32'h11223344);
        wr(32'h206, 3'd1, 32'hBBBB0000);
        rd(32'h204);
        idle();
        check_eq("byte_merge_ref", ref_mem[18'h80], 32'h11AA3344);
        check_eq("half_merge_ref", ref_mem[18'h81], 32'hBBBB3344);

        // Misaligned word write, then a read presented during ERR2
        wr(32'h101, 3'd2, 32'h12345678);
        rd(32'h100);
        idle();

        // Back-to-back pipelined traffic
        wr(32'h0, 3'd2, 32'hA5A5A5A5);
        rd(32'h4);
        wr(32'h8, 3'd2, 32'h0F0F0F0F);
        rd(32'h0);
        idle();

        // Randomized traffic over a small window to force address reuse
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            bit          sel;
            logic [1:0]  trans;
            logic [2:0]  size;
            r = $urandom_range(0, 7);
            size = (r <= 2) ? 3'(r) : ((r <= 5) ? 3'd2 : 3'(r));
            if ($urandom_range(0, 4) == 0) begin
                sel   = 1'($urandom_range(0, 1));
                trans = sel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            end else begin
                sel   = 1'b1;
                trans = 2'($urandom_range(2, 3));
            end
            beat(sel, trans, 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), size,
                 $urandom);
        end
        idle();

        // Reset during a write data phase
        wr(32'h300, 3'd2, 32'hCAFEF00D);
        wr(32'h300, 3'd2, 32'h55555555);
        hresetn = 1'b0;
        hsel    = 1'b0;
        htrans  = 2'd0;
        hwdata  = p_wdata;
        @(negedge hclk);
        check_eq("rst_mid_we", 32'(ram_we), 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        p_vld   = 1'b0;
        @(negedge hclk);
        check_eq("post_rst_ready", 32'(hreadyout), 32'd1);
        check_eq("post_rst_resp", 32'(hresp), 32'd0);
        check_eq("post_rst_addr", 32'(ram_a), 32'd0);
        @(posedge hclk); #1;
        rd(32'h300);
        idle();
        check_eq("post_rst_mem", hrdata, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
